// File: rtl/counter_nbit_mod_if.sv
// counter_nbit_mod_if: control and status bundle of the modulo counter
interface counter_nbit_mod_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up;
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] P;
    logic             tc;
    logic             ovf;
    modport master (output en, up, clr, load, load_val, input P, tc, ovf);
    modport slave  (input en, up, clr, load, load_val, output P, tc, ovf);
endinterface

// File: rtl/counter_nbit_mod.sv
// counter_nbit_mod: prescaled up/down modulo counter with wrap or saturate boundary
module counter_nbit_mod #(
    parameter int WIDTH    = 4,
    parameter int MODULO   = 16,
    parameter bit SAT      = 1'b0,
    parameter int PRESCALE = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    counter_nbit_mod_if.slave    bus
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] MAXV  = WIDTH'(MODULO - 1);
    localparam logic [PW-1:0]    PLAST = PW'(PRESCALE - 1);

    if (MODULO < 2 || MODULO > (1 << WIDTH) || PRESCALE < 1) begin : g_bad_params
        $error("counter_nbit_mod: illegal MODULO/WIDTH/PRESCALE combination");
    end

    logic [WIDTH-1:0] p_q, p_d;
    logic [PW-1:0]    pcnt_q, pcnt_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             step;
    logic             at_bnd;

    assign step   = bus.en && (pcnt_q == PLAST);
    assign at_bnd = bus.up ? (p_q == MAXV) : (p_q == '0);

    // next state: clr beats load beats step; out-of-range loads clamp to MODULO-1
    always_comb begin
        p_d    = p_q;
        pcnt_d = pcnt_q;
        tc_d   = 1'b0;
        ovf_d  = ovf_q;
        if (bus.clr) begin
            p_d    = '0;
            pcnt_d = '0;
            ovf_d  = 1'b0;
        end else if (bus.load) begin
            p_d    = (bus.load_val > MAXV) ? MAXV : bus.load_val;
            pcnt_d = '0;
        end else if (bus.en) begin
            pcnt_d = step ? '0 : pcnt_q + 1'b1;
            if (step && at_bnd) begin
                tc_d  = 1'b1;
                ovf_d = 1'b1;
                p_d   = SAT ? p_q : (bus.up ? '0 : MAXV);
            end else if (step) begin
                p_d = bus.up ? p_q + 1'b1 : p_q - 1'b1;
            end
        end
    end

    // state registers, cleared immediately by the active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p_q    <= '0;
            pcnt_q <= '0;
            tc_q   <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            p_q    <= p_d;
            pcnt_q <= pcnt_d;
            tc_q   <= tc_d;
            ovf_q  <= ovf_d;
        end
    end

    assign bus.P   = p_q;
    assign bus.tc  = tc_q;
    assign bus.ovf = ovf_q;
endmodule

// File: tb/tb_counter_nbit_mod.sv
// tb_counter_nbit_mod: directed checks of wrap, saturate and prescaled counter variants
module tb_counter_nbit_mod;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0, up = 1'b0, clr = 1'b0, load = 1'b0;
    logic [3:0] load_val = '0;
    int         n_chk = 0;
    int         n_fail = 0;

    counter_nbit_mod_if #(.WIDTH(4)) bus_w ();
    counter_nbit_mod_if #(.WIDTH(4)) bus_s ();
    counter_nbit_mod_if #(.WIDTH(4)) bus_p ();

    assign {bus_w.en, bus_w.up, bus_w.clr, bus_w.load, bus_w.load_val} = {en, up, clr, load, load_val};
    assign {bus_s.en, bus_s.up, bus_s.clr, bus_s.load, bus_s.load_val} = {en, up, clr, load, load_val};
    assign {bus_p.en, bus_p.up, bus_p.clr, bus_p.load, bus_p.load_val} = {en, up, clr, load, load_val};

    counter_nbit_mod #(.WIDTH(4), .MODULO(10), .SAT(1'b0), .PRESCALE(1)) u_wrap (.clk(clk), .reset(reset), .bus(bus_w));
    counter_nbit_mod #(.WIDTH(4), .MODULO(10), .SAT(1'b1), .PRESCALE(1)) u_sat  (.clk(clk), .reset(reset), .bus(bus_s));
    counter_nbit_mod #(.WIDTH(4), .MODULO(10), .SAT(1'b0), .PRESCALE(3)) u_pre  (.clk(clk), .reset(reset), .bus(bus_p));

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        #3;
        check("rst_P", bus_w.P, 0);
        check("rst_tc", bus_w.tc, 0);
        check("rst_ovf", bus_w.ovf, 0);
        tick();
        reset = 1'b1;

        do_clr();
        en = 1'b1;
        up = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            check($sformatf("wrap_up_P%0d", i), bus_w.P, i % 10);
            check($sformatf("wrap_up_tc%0d", i), bus_w.tc, (i == 10) ? 1 : 0);
            check($sformatf("wrap_up_ovf%0d", i), bus_w.ovf, (i == 10) ? 1 : 0);
        end
        tick();
        check("wrap_after_P", bus_w.P, 1);
        check("wrap_after_tc", bus_w.tc, 0);
        check("wrap_after_ovf", bus_w.ovf, 1);

        do_clr();
        up = 1'b0;
        tick();
        check("wrap_dn_P", bus_w.P, 9);
        check("wrap_dn_tc", bus_w.tc, 1);
        check("wrap_dn_ovf", bus_w.ovf, 1);
        tick();
        check("wrap_dn2_P", bus_w.P, 8);
        check("wrap_dn2_tc", bus_w.tc, 0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_P", bus_w.P, 0);
        check("clr_ovf", bus_w.ovf, 0);
        check("clr_tc", bus_w.tc, 0);

        en = 1'b0;
        do_clr();
        load = 1'b1;
        load_val = 4'd8;
        tick();
        load = 1'b0;
        check("sat_load_P", bus_s.P, 8);
        en = 1'b1;
        up = 1'b1;
        tick();
        check("sat_P9", bus_s.P, 9);
        check("sat_P9_tc", bus_s.tc, 0);
        check("sat_P9_ovf", bus_s.ovf, 0);
        tick();
        check("sat_hold1_P", bus_s.P, 9);
        check("sat_hold1_tc", bus_s.tc, 1);
        check("sat_hold1_ovf", bus_s.ovf, 1);
        tick();
        check("sat_hold2_P", bus_s.P, 9);
        check("sat_hold2_tc", bus_s.tc, 1);
        up = 1'b0;
        tick();
        check("sat_dn_P", bus_s.P, 8);
        check("sat_dn_tc", bus_s.tc, 0);
        check("sat_dn_ovf", bus_s.ovf, 1);
        en = 1'b0;
        tick();
        check("sat_idle_P", bus_s.P, 8);
        check("sat_idle_tc", bus_s.tc, 0);

        do_clr();
        en = 1'b1;
        up = 1'b1;
        tick();
        check("pre_e1", bus_p.P, 0);
        tick();
        check("pre_e2", bus_p.P, 0);
        tick();
        check("pre_e3", bus_p.P, 1);
        tick();
        check("pre_e4", bus_p.P, 1);
        en = 1'b0;
        tick();
        tick();
        check("pre_gap", bus_p.P, 1);
        en = 1'b1;
        tick();
        check("pre_e5", bus_p.P, 1);
        tick();
        check("pre_e6", bus_p.P, 2);

        en = 1'b0;
        load = 1'b1;
        load_val = 4'd12;
        tick();
        check("load_clamp", bus_w.P, 9);
        clr = 1'b1;
        load_val = 4'd5;
        tick();
        clr = 1'b0;
        check("clr_over_load", bus_w.P, 0);
        load = 1'b0;
        en = 1'b1;
        tick();
        load = 1'b1;
        load_val = 4'd3;
        tick();
        load = 1'b0;
        check("pre_load_P", bus_p.P, 3);
        tick();
        tick();
        check("pre_load_hold", bus_p.P, 3);
        tick();
        check("pre_load_step", bus_p.P, 4);

        en = 1'b0;
        do_clr();
        en = 1'b1;
        up = 1'b0;
        tick();
        en = 1'b0;
        load = 1'b1;
        load_val = 4'd7;
        tick();
        load = 1'b0;
        check("pre_rst_P", bus_w.P, 7);
        check("pre_rst_ovf", bus_w.ovf, 1);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_P", bus_w.P, 0);
        check("async_rst_ovf", bus_w.ovf, 0);
        check("async_rst_tc", bus_w.tc, 0);
        check("async_rst_preP", bus_p.P, 0);
        reset = 1'b1;
        en = 1'b1;
        up = 1'b1;
        tick();
        check("resume_w", bus_w.P, 1);
        check("resume_p1", bus_p.P, 0);
        tick();
        check("resume_p2", bus_p.P, 0);
        tick();
        check("resume_p3", bus_p.P, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/counter_nbit_mod.md
COUNTER_NBIT_MOD -- requirements
Module: counter_nbit_mod

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- WIDTH, 4, bit width of count output P.
- MODULO, 16, count range 0..MODULO-1; legal range 2..2**WIDTH.
- SAT, 0, boundary mode: 0 = wrap, 1 = saturate.
- PRESCALE, 1, enabled cycles per count step; legal range >=1.
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  count enable; advances the prescaler.
- up  input  1  direction: 1 = increment, 0 = decrement.
- clr  input  1  synchronous clear.
- load  input  1  synchronous load of load_val.
- load_val  input  WIDTH  value to load.
- P  output  WIDTH  current count, registered.
- tc  output  1  registered one-cycle terminal-count pulse.
- ovf  output  1  sticky boundary flag, registered.
REQ-003 Elaboration SHALL fail (assertion/$error) if MODULO<2, MODULO>2**WIDTH or PRESCALE<1.

Function
REQ-004 Priority per rising edge SHALL be clr > load > step > hold.
REQ-005 clr=1 SHALL set P=0, prescaler=0, tc=0, ovf=0 next cycle regardless of en/load.
REQ-006 load=1 (clr=0) SHALL set P=load_val if load_val<MODULO, else P=MODULO-1; prescaler=0; tc=0; ovf unchanged.
REQ-007 Internal prescaler pcnt, width max(1,$clog2(PRESCALE)): en=1 increments pcnt; en=0 holds pcnt.
REQ-008 A step SHALL occur on an edge with en=1 and pcnt==PRESCALE-1; pcnt returns to 0 on that edge; PRESCALE=1 gives a step every enabled cycle.
REQ-009 up SHALL be sampled only on the step edge; changing up between steps does not disturb pcnt.
REQ-010 Up step, P<MODULO-1: P<=P+1; P==MODULO-1: P<=0 (SAT=0) or hold MODULO-1 (SAT=1).
REQ-011 Down step, P>0: P<=P-1; P==0: P<=MODULO-1 (SAT=0) or hold 0 (SAT=1).
REQ-012 A boundary event is a step taken at the REQ-010/011 boundary value; it SHALL set tc=1 for exactly the following cycle and set ovf=1.
REQ-013 tc SHALL be 0 in every cycle not directly following a boundary event; back-to-back boundary events (SAT=1, PRESCALE=1) SHALL hold tc=1 continuously.
REQ-014 ovf SHALL remain 1 until clr or reset.
REQ-015 P SHALL never leave 0..MODULO-1; arithmetic SHALL be WIDTH bits with no reliance on natural wrap when MODULO<2**WIDTH.
REQ-016 en=0 with no clr/load SHALL hold P, pcnt and ovf, and drive tc=0 next cycle.

Reset
REQ-017 reset=0 SHALL immediately, without a clock edge, force P=0, pcnt=0, tc=0, ovf=0.
REQ-018 reset SHALL override clr, load and en; first step after deassertion SHALL require a full PRESCALE enabled cycles.
REQ-019 Reset asserted mid-count or mid-prescale SHALL discard all progress; no partial step completes.

Verification
REQ-020 WIDTH=4, MODULO=10, SAT=0, PRESCALE=1, up=1, en=1 from 0: P=0..9, 0; tc=1 only in cycle after the 9->0 edge; ovf=1 thereafter.
REQ-021 Same config, up=0 from P=0: next P=9, tc pulse, ovf=1; then clr -> P=0, ovf=0, tc=0.
REQ-022 SAT=1, MODULO=10, up=1 from P=8: P=9, then holds 9; tc=1 every cycle after first hold attempt; ovf=1; up=0 then P=8, tc=0.
REQ-023 PRESCALE=3, en=1 from 0: P increments every 3rd edge; en=0 for 2 cycles mid-prescale extends interval by exactly 2 cycles.
REQ-024 MODULO=10: load_val=12 -> P=9; clr=1 with load=1, load_val=5 -> P=0; load during prescale -> next step after 3 enabled cycles.
REQ-025 reset=0 pulsed between clock edges at P=7, ovf=1: P=0, ovf=0, tc=0 before next edge; counting resumes from 0 after release.
